spram_rr_arbiter: RTL and testbench



---
 rtl/spram_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_spram_rr_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// spram_rr_arbiter
//   Two-requester round-robin arbiter and sequencer in front of a single-port
//   SRAM (active-low CEB/WEB, Q valid one cycle after a read access).
//   At most one SRAM access per cycle. Each requester has a valid/ready
//   request channel and a registered, backpressured read-response channel.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready[2]  request handshake, bit i = requester i
//   req_we[2]           1 = write, 0 = read
//   req_addr[2*AW]      requester i address in [i*AW +: AW]
//   req_wdata[2*DW]     requester i write data in [i*DW +: DW]
//   rsp_valid/ready[2]  read-response handshake
//   rsp_rdata[2*DW]     read data, requester i in [i*DW +: DW]
//   mem_ceb/web/a/d     SRAM drive (combinational from the granted request)
//   mem_q               SRAM read data, valid the cycle after a read access
//   busy                any read in flight or any response held
// ---------------------------------------------------------------------------
module spram_rr_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [2*DW-1:0] rsp_rdata,
  output logic            mem_ceb,
  output logic            mem_web,
  output logic [AW-1:0]   mem_a,
  output logic [DW-1:0]   mem_d,
  input  logic [DW-1:0]   mem_q,
  output logic            busy
);

  logic            r_ptr;
  logic            r_inflight_v;
  logic            r_inflight_id;
  logic [1:0]      r_rsp_valid;
  logic [2*DW-1:0] r_rsp_rdata;
  logic [AW-1:0]   r_last_a;
  logic [DW-1:0]   r_last_d;

  logic [1:0]      w_free;
  logic [1:0]      w_elig;
  logic [1:0]      w_grant;
  logic            w_gid;
  logic            w_gwe;
  logic [AW-1:0]   w_gaddr;
  logic [DW-1:0]   w_gdata;

  // A response slot counts as free in the cycle its response handshakes,
  // so a requester can re-issue a read while its previous response drains.
  always_comb begin
    w_free[0] = ~(r_inflight_v & ~r_inflight_id) & (~r_rsp_valid[0] | rsp_ready[0]);
    w_free[1] = ~(r_inflight_v &  r_inflight_id) & (~r_rsp_valid[1] | rsp_ready[1]);
    w_elig    = req_valid & (req_we | w_free);
  end

  always_comb begin
    w_grant = 2'b00;
    case (w_elig)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
      default: w_grant = 2'b00;
    endcase
  end

  always_comb begin
    w_gid   = w_grant[1];
    w_gwe   = w_gid ? req_we[1] : req_we[0];
    w_gaddr = w_gid ? req_addr[AW +: AW]  : req_addr[0 +: AW];
    w_gdata = w_gid ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
  end

  // Address/data hold their last granted values while idle to avoid toggling.
  always_comb begin
    req_ready = w_grant;
    mem_ceb   = ~|w_grant;
    mem_web   = (|w_grant) ? ~w_gwe : 1'b1;
    mem_a     = (|w_grant) ? w_gaddr : r_last_a;
    mem_d     = (|w_grant) ? w_gdata : r_last_d;
    rsp_valid = r_rsp_valid;
    rsp_rdata = r_rsp_rdata;
    busy      = r_inflight_v | (|r_rsp_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr         <= 1'b0;
      r_inflight_v  <= 1'b0;
      r_inflight_id <= 1'b0;
      r_rsp_valid   <= '0;
      r_rsp_rdata   <= '0;
      r_last_a      <= '0;
      r_last_d      <= '0;
    end else begin
      if (|w_grant) begin
        r_ptr    <= ~w_gid;
        r_last_a <= w_gaddr;
        r_last_d <= w_gdata;
      end

      r_inflight_v <= (|w_grant) & ~w_gwe;
      if ((|w_grant) & ~w_gwe)
        r_inflight_id <= w_gid;

      for (int unsigned i = 0; i < 2; i++) begin
        if (r_rsp_valid[i] & rsp_ready[i])
          r_rsp_valid[i] <= 1'b0;
      end

      // Capture cannot coincide with a handshake on the same requester
      // (issue requires a free slot); placing it last keeps that explicit.
      if (r_inflight_v) begin
        r_rsp_valid[r_inflight_id] <= 1'b1;
        if (r_inflight_id)
          r_rsp_rdata[DW +: DW] <= mem_q;
        else
          r_rsp_rdata[0 +: DW] <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spram_rr_arbiter
//   Self-checking bench for spram_rr_arbiter with a behavioural SRAM model.
//   A table of arbitration vectors checks round-robin grants; hand-written
//   sequences cover write/read, backpressure, interleaved reads, boundary
//   addresses and reset mid-read. A negedge monitor keeps a reference memory
//   and per-requester response queues (data, owner, latency, stability).
// ---------------------------------------------------------------------------
module tb_spram_rr_arbiter;
  localparam int AW = 8;
  localparam int DW = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          rv  [2];
  logic          rwe [2];
  logic [AW-1:0] ra  [2];
  logic [DW-1:0] rd  [2];
  logic          rr  [2];

  logic [1:0]      req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata, rsp_rdata;
  logic            mem_ceb, mem_web, busy;
  logic [AW-1:0]   mem_a;
  logic [DW-1:0]   mem_d;
  logic [DW-1:0]   mem_q;

  assign req_valid = {rv[1], rv[0]};
  assign req_we    = {rwe[1], rwe[0]};
  assign req_addr  = {ra[1], ra[0]};
  assign req_wdata = {rd[1], rd[0]};
  assign rsp_ready = {rr[1], rr[0]};

  spram_rr_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_ceb(mem_ceb), .mem_web(mem_web), .mem_a(mem_a), .mem_d(mem_d),
    .mem_q(mem_q), .busy(busy)
  );

  // Behavioural single-port SRAM: Q registered one cycle after a read.
  logic [DW-1:0] sram [256];
  initial begin
    for (int k = 0; k < 256; k++) sram[k] = '0;
    mem_q = '0;
  end
  always @(posedge clk) begin
    if (!mem_ceb) begin
      if (!mem_web) sram[mem_a] <= mem_d;
      else          mem_q <= sram[mem_a];
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } ent_t;

  ent_t          q0[$];
  ent_t          q1[$];
  logic [DW-1:0] ref_mem [256];
  logic [1:0]    pv, pr;
  logic [DW-1:0] pd [2];

  initial for (int k = 0; k < 256; k++) ref_mem[k] = '0;

  always @(negedge clk) begin
    ent_t e;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      pv = '0;
      pr = '0;
    end else begin
      chk("one_grant", ($countones(req_ready) <= 1), 1);
      chk("ceb_vs_grant", mem_ceb, ~|req_ready);
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i]) begin
          chk("mem_a", mem_a, ra[i]);
          if (rwe[i]) begin
            chk("mem_web_wr", mem_web, 0);
            chk("mem_d", mem_d, rd[i]);
            ref_mem[ra[i]] = rd[i];
          end else begin
            chk("mem_web_rd", mem_web, 1);
            e.d = ref_mem[ra[i]];
            e.c = cyc;
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (pv[i] && !pr[i]) begin
          chk("rsp_hold", rsp_valid[i], 1);
          chk("rsp_stable", rsp_rdata[i*DW +: DW], pd[i]);
        end
        if (rsp_valid[i] && !pv[i]) begin
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0))
            chk("rsp_unexpected", rsp_valid[i], 0);
          else begin
            e = (i == 0) ? q0[0] : q1[0];
            chk("rsp_latency", cyc - e.c, 2);
          end
        end
        if (rsp_valid[i] && rsp_ready[i]) begin
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0))
            chk("rsp_unexpected", rsp_valid[i], 0);
          else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk("rsp_data", rsp_rdata[i*DW +: DW], e.d);
          end
        end
        pd[i] = rsp_rdata[i*DW +: DW];
      end
      pv = rsp_valid;
      pr = rsp_ready;
    end
  end

  // ---------------- driver helpers (called at posedge+#1) ----------------
  task automatic issue(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    bit got;
    n = 0;
    got = 0;
    rv[i] = 1'b1; rwe[i] = we; ra[i] = a; rd[i] = d;
    while (!got && n < 20) begin
      @(negedge clk); #1;
      if (req_ready[i]) got = 1;
      n++;
    end
    chk("grant_timeout", got, 1);
    @(posedge clk); #1;
    rv[i] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || rsp_valid != 2'b00) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", (n < 50), 1);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata0"}, rsp_rdata[0 +: DW], 0);
    chk({tag, "_rsp_rdata1"}, rsp_rdata[DW +: DW], 0);
    chk({tag, "_mem_ceb"}, mem_ceb, 1);
    chk({tag, "_mem_web"}, mem_web, 1);
    chk({tag, "_mem_a"}, mem_a, 0);
    chk({tag, "_mem_d"}, mem_d, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- arbitration vector table ----------------
  typedef struct {
    logic [1:0] v;
    logic [1:0] we;
    logic [1:0] exp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; rwe[i] = 0; ra[i] = '0; rd[i] = '0; rr[i] = 1;
    end
    // Pointer starts at 0; only writes, so response state never blocks.
    tbl[0]  = '{2'b11, 2'b11, 2'b01};
    tbl[1]  = '{2'b11, 2'b11, 2'b10};
    tbl[2]  = '{2'b11, 2'b11, 2'b01};
    tbl[3]  = '{2'b11, 2'b11, 2'b10};
    tbl[4]  = '{2'b11, 2'b11, 2'b01};
    tbl[5]  = '{2'b11, 2'b11, 2'b10};
    tbl[6]  = '{2'b00, 2'b11, 2'b00};
    tbl[7]  = '{2'b10, 2'b11, 2'b10};
    tbl[8]  = '{2'b11, 2'b11, 2'b01};
    tbl[9]  = '{2'b01, 2'b11, 2'b01};
    tbl[10] = '{2'b11, 2'b11, 2'b10};

    #2 rst_n = 1'b0;
    #20;
    reset_chk("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin table
    for (int k = 0; k < 11; k++) begin
      rv[0] = tbl[k].v[0]; rwe[0] = tbl[k].we[0];
      rv[1] = tbl[k].v[1]; rwe[1] = tbl[k].we[1];
      ra[0] = 8'(8'h80 + k);
      ra[1] = 8'(8'h90 + k);
      rd[0] = {8{32'(32'h1000_0000 + k)}};
      rd[1] = {8{32'(32'h2000_0000 + k)}};
      @(negedge clk); #1;
      chk("rr_grant", req_ready, tbl[k].exp);
      @(posedge clk); #1;
    end
    rv[0] = 0; rv[1] = 0;

    // Single write then read, with idle hold of address/data
    issue(0, 1'b1, 8'h12, {8{32'hA5A5_0001}});
    @(negedge clk); #1;
    chk("idle_ceb", mem_ceb, 1);
    chk("idle_web", mem_web, 1);
    chk("hold_a", mem_a, 8'h12);
    chk("hold_d", mem_d, {8{32'hA5A5_0001}});
    @(posedge clk); #1;
    issue(0, 1'b0, 8'h12, '0);
    drain();

    // Response backpressure on requester 1
    issue(1, 1'b1, 8'h40, {8{32'h4040_4040}});
    issue(1, 1'b1, 8'h41, {8{32'h4141_4141}});
    rr[1] = 0;
    issue(1, 1'b0, 8'h40, '0);
    rv[1] = 1; rwe[1] = 0; ra[1] = 8'h41;
    fork
      begin
        repeat (5) begin
          @(negedge clk); #1;
          chk("bp_block", req_ready[1], 0);
          chk("bp_busy", busy, 1);
        end
      end
      begin
        issue(0, 1'b1, 8'h81, {8{32'hC0DE_0081}});
        issue(0, 1'b1, 8'h82, {8{32'hC0DE_0082}});
        issue(0, 1'b1, 8'h83, {8{32'hC0DE_0083}});
      end
    join
    @(posedge clk); #1;
    rr[1] = 1;
    @(negedge clk); #1;
    chk("bp_grant_in_hs", req_ready[1], 1);
    chk("bp_rsp_valid", rsp_valid[1], 1);
    @(posedge clk); #1;
    rv[1] = 0;
    drain();

    // Interleaved reads: one access every cycle
    issue(0, 1'b1, 8'h01, {8{32'h0101_0101}});
    issue(1, 1'b1, 8'h02, {8{32'h0202_0202}});
    rv[0] = 1; rwe[0] = 0; ra[0] = 8'h01;
    rv[1] = 1; rwe[1] = 0; ra[1] = 8'h02;
    repeat (10) begin
      @(negedge clk); #1;
      chk("il_access", mem_ceb, 0);
    end
    @(posedge clk); #1;
    rv[0] = 0; rv[1] = 0;
    drain();

    // Boundary addresses from opposite requesters
    issue(0, 1'b1, 8'hFF, {8{32'hFFFF_0FF0}});
    issue(1, 1'b1, 8'h00, {8{32'h0000_5A5A}});
    issue(1, 1'b0, 8'hFF, '0);
    issue(0, 1'b0, 8'h00, '0);
    drain();

    // Reset asserted while a read is in flight
    rr[0] = 0;
    issue(0, 1'b0, 8'h12, '0);
    rst_n = 1'b0;
    #1;
    reset_chk("midrst");
    @(negedge clk) rst_n = 1'b1;
    rr[0] = 1;
    repeat (5) begin
      @(negedge clk); #1;
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_ceb", mem_ceb, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
